// File: rtl/mx_stim_pkg.sv
// Shared definitions for the MX FP32 stimulus generator.
// Holds FP32 field geometry, special exponents, the lane LFSR polynomial,
// the category and FSM state enums, and small helpers for seeding,
// exponent clamping and LFSR stepping.
package mx_stim_pkg;

  localparam int unsigned FP32_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;

  localparam logic [EXP_W-1:0] EXP_NAN  = 8'hFF;
  localparam logic [EXP_W-1:0] EXP_MAXN = 8'hFE;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LANE_SEED_STEP = 32'h9E37_79B9;

  typedef enum logic [3:0] {
    CatNormal   = 4'd0,
    CatCarry    = 4'd1,
    CatTie      = 4'd2,
    CatManOvf   = 4'd3,
    CatScaleOvf = 4'd4,
    CatNan      = 4'd5,
    CatSubnorm  = 4'd6,
    CatZero     = 4'd7,
    CatSweep    = 4'd8
  } mx_cat_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mx_state_e;

  // Per-lane seed; an all-zero state would lock the LFSR, so it becomes 1.
  function automatic logic [31:0] lane_seed(logic [31:0] seed, int unsigned lane);
    logic [31:0] s;
    s = seed ^ (lane * LANE_SEED_STEP);
    if (s == 32'h0) s = 32'h1;
    return s;
  endfunction

  // Keep a random exponent inside the normal range 1..254.
  function automatic logic [EXP_W-1:0] clamp_exp(logic [EXP_W-1:0] e);
    logic [EXP_W-1:0] c;
    c = e;
    if (e == 8'h00) c = 8'h01;
    else if (e == EXP_NAN) c = EXP_MAXN;
    return c;
  endfunction

  // Right-shifting Galois step.
  function automatic logic [31:0] lfsr_next(logic [31:0] r);
    return r[0] ? ((r >> 1) ^ LFSR_POLY) : (r >> 1);
  endfunction

endpackage

// File: rtl/mx_stim_lfsr32.sv
// 32-bit Galois LFSR for one stimulus lane.
// Ports:
//   clk_i    clock
//   load_i   synchronous load of SEED (priority over step)
//   step_i   advance one step
//   state_o  current LFSR state
module mx_stim_lfsr32
  import mx_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk_i,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] state_d, state_q;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (SEED == 32'h0) ? 32'h1 : SEED;
    end else if (step_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i) begin
    state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/mx_fp32_stim_gen.sv
// FP32 stimulus generator for MXINT8 block converters.
// Streams MX blocks of BLOCK_SIZE FP32 elements, LANES per beat, each block
// drawn from one corner-case category. One LFSR per lane supplies randomness
// and advances only on accepted beats.
// Optional build macro: MXSTIM_SWEEP_EN enables cat_sel_i=8 (sweep all
// categories 0..7, num_blocks each); without it 8 behaves as NORMAL.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start_i         start pulse, honoured only in idle
//   cat_sel_i       block category (9..15 -> NORMAL)
//   sign_mode_i     0 +, 1 -, 2 alternate per block, 3 lane-0 LFSR bit 31
//   num_blocks_i    blocks per category (0 -> 1)
//   data_o          LANES FP32 elements, lane i at [32i+31:32i]
//   valid_o/ready_i stream handshake; last_o marks final beat of a block
//   busy_o, done_o  run status; done_o pulses one cycle at completion
module mx_fp32_stim_gen
  import mx_stim_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned CNT_W      = 16,
  parameter logic [31:0] SEED       = 32'hACE1_2468
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [3:0]                cat_sel_i,
  input  logic [1:0]                sign_mode_i,
  input  logic [CNT_W-1:0]          num_blocks_i,
  output logic [LANES*FP32_W-1:0]   data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned BEATS  = BLOCK_SIZE / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BEATS - 1);

  mx_state_e state_d, state_q;
  logic [BEAT_W-1:0] beat_cnt_d, beat_cnt_q;
  logic [CNT_W-1:0] blk_cnt_d, blk_cnt_q;
  logic [CNT_W-1:0] nb_d, nb_q;
  mx_cat_e cat_d, cat_q;
  logic [1:0] sign_mode_d, sign_mode_q;
  logic par_d, par_q;
  logic blk_sign_d, blk_sign_q;
  logic [EXP_W-1:0] blk_exp_d, blk_exp_q;

  logic [LANES-1:0][FP32_W-1:0] lane_r;
  logic [LANES*FP32_W-1:0] elems;
  mx_cat_e cur_cat;
  logic sweep_more;
  logic xfer;
  logic blk_start;
  logic cur_bsign;
  logic [EXP_W-1:0] cur_bexp;
  logic elem_sign;

  // Lane LFSRs: reloaded while in reset, stepped on every accepted beat.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mx_stim_lfsr32 #(
      .SEED (lane_seed(SEED, g))
    ) u_lfsr (
      .clk_i   (clk),
      .load_i  (~rst_n),
      .step_i  (xfer),
      .state_o (lane_r[g])
    );
  end

`ifdef MXSTIM_SWEEP_EN
  logic sweep_d, sweep_q;
  logic [2:0] cat_idx_d, cat_idx_q;
  assign cur_cat    = sweep_q ? mx_cat_e'({1'b0, cat_idx_q}) : cat_q;
  assign sweep_more = sweep_q && (cat_idx_q != 3'd7);
`else
  assign cur_cat    = cat_q;
  assign sweep_more = 1'b0;
`endif

  assign valid_o = (state_q == StRun);
  assign busy_o  = (state_q != StIdle);
  assign done_o  = (state_q == StDone);
  assign last_o  = valid_o && (beat_cnt_q == BEAT_MAX);
  assign xfer    = valid_o && ready_i;

  // Block-wide sign/exponent come from lane 0 on the first beat and are
  // held in registers for the remaining beats of the block.
  assign blk_start = (beat_cnt_q == '0);
  assign cur_bsign = blk_start ? lane_r[0][31] : blk_sign_q;
  assign cur_bexp  = blk_start ? clamp_exp(lane_r[0][30:23]) : blk_exp_q;

  always_comb begin
    elem_sign = 1'b0;
    unique case (sign_mode_q)
      2'd0: elem_sign = 1'b0;
      2'd1: elem_sign = 1'b1;
      2'd2: elem_sign = par_q;
      2'd3: elem_sign = cur_bsign;
      default: elem_sign = 1'b0;
    endcase
  end

  always_comb begin
    logic [FP32_W-1:0] r;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    r = '0;
    e = '0;
    m = '0;
    elems = '0;
    for (int i = 0; i < LANES; i++) begin
      r = lane_r[i];
      case (cur_cat)
        CatCarry: begin
          e = clamp_exp(r[30:23]);
          m = {7'h7F, 1'b1, r[14:0]};
        end
        CatTie: begin
          e = clamp_exp(r[30:23]);
          m = {r[22:16], 1'b1, 15'h0};
        end
        CatManOvf: begin
          e = cur_bexp;
          m = 23'h7F_FFFF;
        end
        CatScaleOvf: begin
          e = EXP_MAXN;
          m = {7'h7F, 1'b1, r[14:0]};
        end
        CatNan: begin
          e = EXP_NAN;
          m = r[22:0] | 23'h40_0000;
        end
        CatSubnorm: begin
          e = '0;
          m = r[22:0] | 23'h1;
        end
        CatZero: begin
          e = r[30:23];
          m = '0;
        end
        default: begin
          e = clamp_exp(r[30:23]);
          m = r[22:0];
        end
      endcase
      elems[i*FP32_W +: FP32_W] = {elem_sign, e, m};
    end
  end

  assign data_o = valid_o ? elems : '0;

  // Bit 31 of lanes other than 0 is never consumed.
  logic unused_lane_msb;
  always_comb begin
    unused_lane_msb = 1'b0;
    for (int i = 0; i < LANES; i++) unused_lane_msb ^= lane_r[i][31];
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    nb_d        = nb_q;
    cat_d       = cat_q;
    sign_mode_d = sign_mode_q;
    par_d       = par_q;
    blk_sign_d  = blk_sign_q;
    blk_exp_d   = blk_exp_q;
`ifdef MXSTIM_SWEEP_EN
    sweep_d     = sweep_q;
    cat_idx_d   = cat_idx_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StRun;
          beat_cnt_d  = '0;
          blk_cnt_d   = '0;
          par_d       = 1'b0;
          nb_d        = (num_blocks_i == '0) ? CNT_W'(1) : num_blocks_i;
          sign_mode_d = sign_mode_i;
          cat_d       = (cat_sel_i > 4'd7) ? CatNormal : mx_cat_e'(cat_sel_i);
`ifdef MXSTIM_SWEEP_EN
          sweep_d     = (cat_sel_i == CatSweep);
          cat_idx_d   = '0;
`endif
        end
      end
      StRun: begin
        if (xfer) begin
          if (blk_start) begin
            blk_sign_d = cur_bsign;
            blk_exp_d  = cur_bexp;
          end
          if (beat_cnt_q == BEAT_MAX) begin
            beat_cnt_d = '0;
            par_d      = ~par_q;
            if (blk_cnt_q == nb_q - CNT_W'(1)) begin
              blk_cnt_d = '0;
              if (sweep_more) begin
`ifdef MXSTIM_SWEEP_EN
                cat_idx_d = cat_idx_q + 3'd1;
`endif
              end else begin
                state_d = StDone;
              end
            end else begin
              blk_cnt_d = blk_cnt_q + CNT_W'(1);
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      blk_cnt_q   <= '0;
      nb_q        <= CNT_W'(1);
      cat_q       <= CatNormal;
      sign_mode_q <= 2'd0;
      par_q       <= 1'b0;
      blk_sign_q  <= 1'b0;
      blk_exp_q   <= 8'h01;
`ifdef MXSTIM_SWEEP_EN
      sweep_q     <= 1'b0;
      cat_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      nb_q        <= nb_d;
      cat_q       <= cat_d;
      sign_mode_q <= sign_mode_d;
      par_q       <= par_d;
      blk_sign_q  <= blk_sign_d;
      blk_exp_q   <= blk_exp_d;
`ifdef MXSTIM_SWEEP_EN
      sweep_q     <= sweep_d;
      cat_idx_q   <= cat_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_mx_fp32_stim_gen.sv
// Self-checking bench for mx_fp32_stim_gen: a block-level reference model
// (lane LFSR states, beat/block/category position, run state) is checked
// against the DUT on every falling edge, plus literal values for the first
// beats after reset and per-run beat/last counts.
module tb_mx_fp32_stim_gen;

  localparam int LANES      = 4;
  localparam int BLOCK_SIZE = 32;
  localparam int CNT_W      = 16;
  localparam int BPB        = BLOCK_SIZE / LANES;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic ready_i = 1'b0;
  logic [3:0] cat_sel_i = '0;
  logic [1:0] sign_mode_i = '0;
  logic [CNT_W-1:0] num_blocks_i = '0;
  logic [LANES*32-1:0] data_o;
  logic valid_o, last_o, busy_o, done_o;

  mx_fp32_stim_gen #(
    .LANES      (LANES),
    .BLOCK_SIZE (BLOCK_SIZE),
    .CNT_W      (CNT_W),
    .SEED       (SEED)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .cat_sel_i    (cat_sel_i),
    .sign_mode_i  (sign_mode_i),
    .num_blocks_i (num_blocks_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] seed_of(input int i);
    logic [31:0] s;
    s = SEED ^ (32'(i) * 32'h9E37_79B9);
    if (s == 32'h0) s = 32'h1;
    return s;
  endfunction

  function automatic logic [31:0] step(input logic [31:0] r);
    return r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
  endfunction

  function automatic logic [7:0] clampe(input logic [7:0] e);
    if (e == 8'd0) return 8'd1;
    if (e == 8'd255) return 8'd254;
    return e;
  endfunction

  function automatic logic [31:0] elem(input int cat, input logic [31:0] r, input logic s,
                                       input logic [7:0] bexp);
    logic [7:0] e;
    logic [22:0] m;
    case (cat)
      0: begin e = clampe(r[30:23]); m = r[22:0]; end
      1: begin e = clampe(r[30:23]); m = {7'h7F, 1'b1, r[14:0]}; end
      2: begin e = clampe(r[30:23]); m = {r[22:16], 1'b1, 15'h0}; end
      3: begin e = bexp; m = 23'h7F_FFFF; end
      4: begin e = 8'hFE; m = {7'h7F, 1'b1, r[14:0]}; end
      5: begin e = 8'hFF; m = r[22:0] | 23'h40_0000; end
      6: begin e = 8'h00; m = r[22:0] | 23'h1; end
      default: begin e = r[30:23]; m = 23'h0; end
    endcase
    return {s, e, m};
  endfunction

  int m_st = 0;  // 0 idle, 1 run, 2 done
  logic [31:0] m_lane [LANES];
  int m_beat, m_blk, m_nb, m_cat, m_sm;
  bit m_sweep, m_par, m_bsign;
  logic [7:0] m_bexp;
  int run_xfers, run_lasts, xfer_since_rst;
  bit pin_en = 1'b0;
  int rdy_mode = 0;

  always @(negedge clk) begin
    logic s;
    logic [31:0] got;
    check("valid", 32'(valid_o), 32'(m_st == 1));
    check("busy", 32'(busy_o), 32'(m_st != 0));
    check("done", 32'(done_o), 32'(m_st == 2));
    if (m_st == 1) begin
      if (m_beat == 0) begin
        m_bsign = m_lane[0][31];
        m_bexp  = clampe(m_lane[0][30:23]);
      end
      case (m_sm)
        0: s = 1'b0;
        1: s = 1'b1;
        2: s = m_par;
        default: s = m_bsign;
      endcase
      for (int i = 0; i < LANES; i++) begin
        got = data_o[32*i +: 32];
        check("data", got, elem(m_cat, m_lane[i], s, m_bexp));
        if (m_cat == 2) begin
          check("tie_man_lo", 32'(got[15:0]), 32'h8000);
          check("tie_exp_range", 32'(got[30:23] >= 8'd1 && got[30:23] <= 8'd254), 32'd1);
        end else if (m_cat == 5) begin
          check("nan_exp", 32'(got[30:23]), 32'hFF);
          check("nan_quiet", 32'(got[22]), 32'd1);
        end else if (m_cat == 7) begin
          check("zero_man", 32'(got[22:0]), 32'd0);
        end
      end
      check("last", 32'(last_o), 32'(m_beat == BPB - 1));
      if (pin_en && xfer_since_rst == 0) begin
        check("pin_l0_beat0", data_o[31:0], 32'h2CE1_2468);
        check("pin_l1_beat0", data_o[63:32], 32'h32D6_5DD1);
      end
      if (pin_en && xfer_since_rst == 1) check("pin_l0_beat1", data_o[31:0], 32'h5670_9234);
    end else begin
      check("last_idle", 32'(last_o), 32'd0);
    end
    if (valid_o && ready_i) begin
      run_xfers++;
      if (last_o) run_lasts++;
    end
    // advance the model with the inputs the DUT sees at the next rising edge
    if (!rst_n) begin
      m_st = 0;
      xfer_since_rst = 0;
      for (int i = 0; i < LANES; i++) m_lane[i] = seed_of(i);
    end else begin
      case (m_st)
        0: if (start_i) begin
          m_st = 1; m_beat = 0; m_blk = 0; m_par = 1'b0;
          m_nb = (num_blocks_i == 0) ? 1 : int'(num_blocks_i);
          m_sm = int'(sign_mode_i);
          m_cat = (cat_sel_i > 4'd7) ? 0 : int'(cat_sel_i);
`ifdef MXSTIM_SWEEP_EN
          m_sweep = (cat_sel_i == 4'd8);
`else
          m_sweep = 1'b0;
`endif
        end
        1: if (ready_i) begin
          xfer_since_rst++;
          for (int i = 0; i < LANES; i++) m_lane[i] = step(m_lane[i]);
          if (m_beat == BPB - 1) begin
            m_beat = 0;
            m_par = !m_par;
            if (m_blk == m_nb - 1) begin
              m_blk = 0;
              if (m_sweep && m_cat < 7) m_cat++;
              else m_st = 2;
            end else begin
              m_blk++;
            end
          end else begin
            m_beat++;
          end
        end
        default: m_st = 0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: ready_i = 1'b1;
        1: ready_i = ~ready_i;
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic run(input int cat, input int sm, input int nb, input int rm);
    int ncat, nbe;
    bit seen;
    rdy_mode = rm;
    @(posedge clk);
    #1;
    cat_sel_i = 4'(cat);
    sign_mode_i = 2'(sm);
    num_blocks_i = CNT_W'(nb);
    start_i = 1'b1;
    run_xfers = 0;
    run_lasts = 0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    // inputs are latched at start; scramble them to prove it
    cat_sel_i = 4'($urandom);
    sign_mode_i = 2'($urandom);
    num_blocks_i = CNT_W'($urandom_range(0, 9));
    seen = 1'b0;
    for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("run_done_seen", 32'(seen), 32'd1);
    ncat = 1;
`ifdef MXSTIM_SWEEP_EN
    if (cat == 8) ncat = 8;
`endif
    nbe = (nb == 0) ? 1 : nb;
    check("run_beats", 32'(run_xfers), 32'(nbe * ncat * BPB));
    check("run_lasts", 32'(run_lasts), 32'(nbe * ncat));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    pin_en = 1'b1;
    run(0, 0, 1, 0);   // NORMAL, pinned first beats
    pin_en = 1'b0;
    run(2, 0, 1, 0);   // TIE, 8 beats, done one cycle after last
    run(5, 2, 2, 0);   // NAN, alternating sign
    run(0, 3, 2, 1);   // backpressure 1010...
    run(7, 1, 0, 2);   // ZERO, num_blocks 0 -> 1
    run(3, 3, 2, 2);   // MAN_OVF, LFSR sign
    run(8, 2, 1, 2);   // SWEEP or NORMAL depending on build

    // reset in the middle of a block
    rdy_mode = 0;
    @(posedge clk);
    #1;
    cat_sel_i = 4'd0; sign_mode_i = 2'd0; num_blocks_i = CNT_W'(2); start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    pin_en = 1'b1;
    run(0, 0, 1, 0);
    pin_en = 1'b0;

    for (int k = 0; k < 8; k++) begin
      run(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 2);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mx_fp32_stim_gen.md
Name: mx_fp32_stim_gen

Overview:
- Synthesizable, parametrised FP32 stimulus generator for the MXINT8 block-data converter benches and FPGA self-test.
- Emits MX blocks of BLOCK_SIZE FP32 elements, LANES elements per beat, over a valid/ready stream.
- Each block is drawn from one corner-case category: normal, carry, tie-to-even, mantissa overflow, scale overflow, NaN, subnormal or zero.
- Sign policy and block count are programmable; an optional sweep mode runs all categories back to back.

Parameters:
- LANES, 4: FP32 elements per output beat; must divide BLOCK_SIZE.
- BLOCK_SIZE, 32: elements per MX block.
- CNT_W, 16: width of the block counter.
- SEED, 32'hACE1_2468: base LFSR seed.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  one-cycle start pulse; ignored unless the FSM is in IDLE.
- cat_sel_i  in  4  category: 0 NORMAL, 1 CARRY, 2 TIE, 3 MAN_OVF, 4 SCALE_OVF, 5 NAN, 6 SUBNORM, 7 ZERO, 8 SWEEP.
- sign_mode_i  in  2  0 all +, 1 all -, 2 alternate per block starting +, 3 LFSR bit 31.
- num_blocks_i  in  CNT_W  blocks per category; 0 is treated as 1.
- data_o  out  LANES*32  lane i occupies [32i+31:32i].
- valid_o  out  1  beat valid.
- ready_i  in  1  sink ready.
- last_o  out  1  final beat of a block.
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle pulse when the run completes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0.
  - FSM goes to IDLE.
  - Each lane LFSR loads SEED ^ (i*32'h9E37_79B9); an all-zero result is replaced with 1.
  - Reset wins over every other event, including mid-block; no partial block is resumed.
- FSM states: IDLE -> RUN on start_i; RUN -> DONE after the last beat of the last block is accepted; DONE -> IDLE after one cycle.
  - done_o is high only in DONE.
  - busy_o is high in RUN and DONE.
- Start latency: start_i accepted in cycle t, so valid_o=1 from cycle t+1.
  - cat_sel_i, sign_mode_i and num_blocks_i are latched at start and ignored thereafter.
- Handshake:
  - A beat transfers when valid_o & ready_i.
  - data_o and last_o hold stable while valid_o & !ready_i.
  - valid_o never drops in RUN until the final transfer.
  - The LFSRs advance only on a transfer.
- Counters:
  - beat_cnt runs 0..BLOCK_SIZE/LANES-1; last_o = (beat_cnt == max).
  - blk_cnt runs 0..N-1.
  - The block sign is fixed per block, so all elements in a block share the same sign.
- Element format: r is the lane LFSR state; element = {s, e[7:0], m[22:0]}.
  - NORMAL: e = r[30:23] clamped to 1..254; m = r[22:0].
  - CARRY: e as NORMAL; m = {7'h7F, 1'b1, r[14:0]}.
  - TIE: e as NORMAL; m = {r[22:16], 1'b1, 15'h0}. Both even and odd r[16] occur.
  - MAN_OVF: e = block base exponent (lane 0 r[30:23] clamped at block start); m = 23'h7FFFFF.
  - SCALE_OVF: e = 8'hFE; m = {7'h7F, 1'b1, r[14:0]}.
  - NAN: e = 8'hFF; m = r[22:0] | 23'h400000.
  - SUBNORM: e = 0; m = r[22:0] | 23'h1.
  - ZERO: e = r[30:23]; m = 0. ±0 occurs when e = 0.
- Sign mode 3: s = r[31] taken from lane 0 at block start.
- Out-of-range cat_sel_i (9..15) is treated as NORMAL.
- SWEEP (only when MXSTIM_SWEEP_EN is defined): runs categories 0..7 in order, N blocks each.
  - The category index advances on the last_o transfer of block N-1.
  - The run ends after ZERO.

Optional Feature:
- MXSTIM_SWEEP_EN defined: cat_sel_i=8 selects SWEEP; a 3-bit cat_idx register and the sweep advance logic are present.
- MXSTIM_SWEEP_EN undefined: cat_sel_i=8 behaves as NORMAL; the sweep logic is absent.

Decomposition:
- Package mx_stim_pkg holds:
  - FP32 field widths and constants: FP32_W=32, EXP_W=8, MAN_W=23, EXP_NAN=8'hFF, EXP_MAXN=8'hFE.
  - The LFSR polynomial 32'h8020_0003.
  - typedef enum logic [3:0] mx_cat_e.
  - typedef enum logic [1:0] for the FSM states.
- One sub-module: mx_stim_lfsr32, a Galois LFSR with seed parameter, load and step inputs, instantiated once per lane.

Test Plan:
- Reset mid-block: rst_n low during beat 3 -> next cycle valid_o=0, busy_o=0; after restart the sequence matches the post-reset golden model exactly.
- cat 2 TIE, LANES=4, BLOCK_SIZE=32, N=1, ready_i=1 -> exactly 8 beats, last_o only on beat 8.
  - Every element has m[15:0]=16'h8000 and exp in 1..254.
  - done_o pulses 1 cycle after the last transfer.
- cat 5 NAN, sign_mode 2, N=2 -> every element exp=8'hFF and m[22]=1; block 0 sign 0, block 1 sign 1.
- Backpressure: ready_i toggling 1010… on cat 0 -> data_o stable during stalls; 8 transfers per block; LFSR steps only on transfers.
- cat 7 ZERO with num_blocks_i=0 -> one block; all m=0; ±0 values are accepted.
- With MXSTIM_SWEEP_EN, cat 8, N=1 -> 8 blocks in category order 0..7, then done_o; without the macro, cat 8 produces NORMAL blocks.
